// File: rtl/i2s_pkg.sv
// Shared types, per-mode constants and slot helpers for the I2S RX sample packer.
package i2s_pkg;

    typedef enum logic [1:0] {
        PACK_32   = 2'b00,
        PACK_16   = 2'b01,
        PACK_8    = 2'b10,
        PACK_RSVD = 2'b11
    } pack_mode_e;

    localparam int SLOTS_32 = 1;
    localparam int SLOTS_16 = 2;
    localparam int SLOTS_8  = 4;

    localparam int WIDTH_32 = 32;
    localparam int WIDTH_16 = 16;
    localparam int WIDTH_8  = 8;

    // Index of the slot that completes a word; the reserved mode behaves like 32-bit.
    function automatic logic [1:0] last_slot(input pack_mode_e mode);
        case (mode)
            PACK_16: return 2'(SLOTS_16 - 1);
            PACK_8:  return 2'(SLOTS_8 - 1);
            default: return 2'(SLOTS_32 - 1);
        endcase
    endfunction

    // Place the low bits of a sample into slot 'slot' of the accumulator.
    function automatic logic [31:0] insert_slot(input logic [31:0] acc,
                                                input logic [31:0] data,
                                                input logic [1:0]  slot,
                                                input pack_mode_e  mode);
        logic [31:0] res;
        logic [4:0]  base;
        res  = acc;
        base = 5'd0;
        case (mode)
            PACK_16: begin
                base = {slot[0], 4'b0000};
                res[base +: WIDTH_16] = data[WIDTH_16-1:0];
            end
            PACK_8: begin
                base = {slot, 3'b000};
                res[base +: WIDTH_8] = data[WIDTH_8-1:0];
            end
            default: res = data[WIDTH_32-1:0];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/i2s_pack_out_stage.sv
// Output register of the sample packer: holds a packed word until the
// downstream side takes it, and remembers whether it came from a flush.
module i2s_pack_out_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    input  logic        load_partial_i,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        out_valid_o,
    output logic        out_partial_o,
    output logic        free_o
);

    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        partial_q, partial_d;

    // A new word may be loaded when the register is empty or being drained this cycle.
    always_comb begin
        free_o    = ~valid_q | out_ready_i;
        data_d    = data_q;
        valid_d   = valid_q;
        partial_d = partial_q;
        if (load_i) begin
            data_d    = load_data_i;
            valid_d   = 1'b1;
            partial_d = load_partial_i;
        end else if (valid_q && out_ready_i) begin
            valid_d   = 1'b0;
            partial_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            partial_q <= partial_d;
        end
    end

    assign out_data_o    = data_q;
    assign out_valid_o   = valid_q;
    assign out_partial_o = partial_q;

endmodule

// File: rtl/i2s_rx_sample_packer.sv
// Packs 32/16/8-bit I2S receive samples into 32-bit words for the uDMA RX channel.
// Optional idle auto-flush is built when I2S_RX_PACKER_TIMEOUT_EN is defined.
module i2s_rx_sample_packer
    import i2s_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_en_i,
    input  logic [1:0]           cfg_pack_mode_i,
    input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
    input  logic                 flush_i,
    input  logic [31:0]          in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [31:0]          out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_partial_o,
    output logic                 busy_o
);

    logic [31:0] acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        flush_pend_q, flush_pend_d;
    pack_mode_e  mode_q, mode_d;

    pack_mode_e  mode_cur;
    logic        mode_chg;
    logic        is_last;
    logic        accept;
    logic        flush_req;
    logic        out_free;
    logic [31:0] acc_ins;
    logic        load;
    logic [31:0] load_data;
    logic        load_partial;

    // Handshake: the last slot may only be taken when the output register can accept the word.
    always_comb begin
        mode_cur   = pack_mode_e'(cfg_pack_mode_i);
        mode_chg   = (mode_cur != mode_q);
        is_last    = (cnt_q >= last_slot(mode_cur));
        in_ready_o = ~rst_i & cfg_en_i & ~flush_pend_q & (~is_last | out_free);
        accept     = in_valid_i & in_ready_o;
        acc_ins    = insert_slot(acc_q, in_data_i, cnt_q, mode_cur);
        busy_o     = (cnt_q != 2'd0) | flush_pend_q;
    end

`ifdef I2S_RX_PACKER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] idle_q, idle_d;
    logic                 timeout_hit;

    // Idle counter: counts cycles a partial word sits untouched and fires an internal flush.
    always_comb begin
        timeout_hit = cfg_en_i & ~flush_pend_q & (cnt_q != 2'd0) &
                      (cfg_timeout_i != '0) & (idle_q >= cfg_timeout_i);
        flush_req   = flush_i | timeout_hit;
        idle_d      = idle_q + 1'b1;
        if (!cfg_en_i || accept || flush_req || flush_pend_q || mode_chg || (cnt_q == 2'd0)) begin
            idle_d = '0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_timeout;

    // Without the idle timer only the explicit request can flush.
    always_comb begin
        flush_req      = flush_i;
        unused_timeout = ^cfg_timeout_i;
    end
`endif

    // Accumulator update, word completion and flush sequencing.
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        mode_d       = mode_cur;
        load         = 1'b0;
        load_data    = acc_q;
        load_partial = 1'b0;
        if (!cfg_en_i) begin
            acc_d        = '0;
            cnt_d        = 2'd0;
            flush_pend_d = 1'b0;
        end else if (flush_pend_q) begin
            if (out_free) begin
                load         = 1'b1;
                load_data    = acc_q;
                load_partial = 1'b1;
                acc_d        = '0;
                cnt_d        = 2'd0;
                flush_pend_d = 1'b0;
            end
        end else if (accept && is_last) begin
            load      = 1'b1;
            load_data = acc_ins;
            acc_d     = '0;
            cnt_d     = 2'd0;
        end else begin
            if (accept) begin
                acc_d = acc_ins;
                cnt_d = cnt_q + 2'd1;
            end
            if (flush_req && (accept || (cnt_q != 2'd0))) begin
                flush_pend_d = 1'b1;
            end
        end
        if (mode_chg) begin
            acc_d        = '0;
            cnt_d        = 2'd0;
            flush_pend_d = 1'b0;
        end
    end

    // Accumulator, slot count, pending flush and registered mode.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q        <= '0;
            cnt_q        <= 2'd0;
            flush_pend_q <= 1'b0;
            mode_q       <= PACK_32;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            mode_q       <= mode_d;
        end
    end

    i2s_pack_out_stage u_out_stage (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .load_i         (load),
        .load_data_i    (load_data),
        .load_partial_i (load_partial),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .out_valid_o    (out_valid_o),
        .out_partial_o  (out_partial_o),
        .free_o         (out_free)
    );

endmodule

// File: tb/tb_i2s_rx_sample_packer.sv
// Self-checking bench for i2s_rx_sample_packer; the idle-timeout scenario is
// included when I2S_RX_PACKER_TIMEOUT_EN is defined.
module tb_i2s_rx_sample_packer;

    logic        clk;
    logic        rst;
    logic        cfg_en;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_timeout;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_partial;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;
    bit rand_ready   = 0;

    logic [31:0] obs_data[$];
    bit          obs_partial[$];
    logic [31:0] exp_data[$];
    bit          exp_partial[$];
    logic [31:0] samples[$];

    i2s_rx_sample_packer #(.TIMEOUT_W(16)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_en_i        (cfg_en),
        .cfg_pack_mode_i (cfg_mode),
        .cfg_timeout_i   (cfg_timeout),
        .flush_i         (flush),
        .in_data_i       (in_data),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .out_data_o      (out_data),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_partial_o   (out_partial),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every word taken by the downstream side.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_data.push_back(out_data);
            obs_partial.push_back(out_partial);
        end
    end

    // Random downstream back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: pack samples by slot arithmetic, append a zero-padded word on flush.
    function automatic void model_words(input int mode, input bit do_flush);
        int          n;
        int          w;
        int          k;
        logic [63:0] word;
        logic [63:0] mask;
        n = (mode == 1) ? 2 : ((mode == 2) ? 4 : 1);
        w = 32 / n;
        mask = (64'd1 << w) - 64'd1;
        word = 64'd0;
        k = 0;
        exp_data.delete();
        exp_partial.delete();
        foreach (samples[i]) begin
            word = word | (({32'd0, samples[i]} & mask) << (k * w));
            k++;
            if (k == n) begin
                exp_data.push_back(word[31:0]);
                exp_partial.push_back(1'b0);
                word = 64'd0;
                k = 0;
            end
        end
        if (do_flush && k > 0) begin
            exp_data.push_back(word[31:0]);
            exp_partial.push_back(1'b1);
        end
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one sample and return #1 after the edge that accepted it; valid stays high.
    task automatic send(input logic [31:0] d, output int stalls);
        in_data  = d;
        in_valid = 1'b1;
        stalls   = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            if (stalls > 200) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL send_timeout got in_ready=0 required 1");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit need_empty);
        int n;
        n = 0;
        while (out_valid || (need_empty && busy)) begin
            step(1);
            n++;
            if (n > 300) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL drain_timeout got out_valid=%0b busy=%0b required 0", out_valid, busy);
                break;
            end
        end
        step(2);
    endtask

    task automatic set_mode(input logic [1:0] m);
        in_valid = 1'b0;
        flush    = 1'b0;
        cfg_en   = 1'b0;
        step(1);
        cfg_mode = m;
        step(2);
        cfg_en = 1'b1;
        step(1);
        obs_data.delete();
        obs_partial.delete();
        samples.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_en = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        step(2);
        tests_run++;
        if (out_data !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_out_data got=%h required=0", out_data); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid got=%b required=0", out_valid); end
        tests_run++;
        if (out_partial !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_partial got=%b required=0", out_partial); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got=%b required=0", busy); end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready got=%b required=0", in_ready); end
        in_valid = 1'b0;
        cfg_en = 1'b0;
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_pack16();
        int st;
        set_mode(2'b01);
        out_ready = 1'b1;
        samples = '{32'h1111AAAA, 32'h2222BBBB};
        send(samples[0], st);
        send(samples[1], st);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hBBBBAAAA || out_partial !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pack16_latency got valid=%b data=%h partial=%b required 1 BBBBAAAA 0", out_valid, out_data, out_partial);
        end
        wait_idle(1'b1);
        model_words(1, 1'b0);
        tests_run++;
        if (obs_data.size() != exp_data.size()) begin
            tests_failed++;
            $display("[TB] FAIL pack16_count got=%0d required=%0d", obs_data.size(), exp_data.size());
        end else begin
            foreach (exp_data[i]) begin
                tests_run++;
                if (obs_data[i] !== exp_data[i] || obs_partial[i] !== exp_partial[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL pack16_word%0d got=%h/%b required=%h/%b", i, obs_data[i], obs_partial[i], exp_data[i], exp_partial[i]);
                end
            end
        end
    endtask

    task automatic test_stream8();
        int st;
        int stall_sum;
        set_mode(2'b10);
        out_ready = 1'b1;
        stall_sum = 0;
        for (int i = 1; i <= 8; i++) begin
            samples.push_back(32'(i * 17));
            send(32'(i * 17), st);
            stall_sum += st;
        end
        in_valid = 1'b0;
        wait_idle(1'b1);
        tests_run++;
        if (stall_sum != 0) begin
            tests_failed++;
            $display("[TB] FAIL stream8_stalls got=%0d required=0", stall_sum);
        end
        model_words(2, 1'b0);
        tests_run++;
        if (obs_data.size() != exp_data.size()) begin
            tests_failed++;
            $display("[TB] FAIL stream8_count got=%0d required=%0d", obs_data.size(), exp_data.size());
        end else begin
            foreach (exp_data[i]) begin
                tests_run++;
                if (obs_data[i] !== exp_data[i] || obs_partial[i] !== exp_partial[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL stream8_word%0d got=%h/%b required=%h/%b", i, obs_data[i], obs_partial[i], exp_data[i], exp_partial[i]);
                end
            end
        end
    endtask

    task automatic test_flush();
        int st;
        set_mode(2'b10);
        out_ready = 1'b1;
        samples = '{32'hFFFFFFA1, 32'h000000B2, 32'h123456C3};
        foreach (samples[i]) send(samples[i], st);
        in_valid = 1'b0;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        wait_idle(1'b1);
        model_words(2, 1'b1);
        tests_run++;
        if (obs_data.size() != 1 || obs_data[0] !== 32'h00C3B2A1 || obs_partial[0] !== 1'b1 ||
            exp_data[0] !== 32'h00C3B2A1) begin
            tests_failed++;
            $display("[TB] FAIL flush_partial got n=%0d data=%h partial=%b required 1 00C3B2A1 1",
                     obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 32'hx,
                     (obs_partial.size() > 0) ? obs_partial[0] : 1'b0);
        end
        obs_data.delete();
        obs_partial.delete();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(6);
        tests_run++;
        if (obs_data.size() != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_empty got words=%0d busy=%b required 0 0", obs_data.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        int st;
        set_mode(2'b00);
        out_ready = 1'b0;
        samples = '{32'hA5A50001, 32'h5A5A0002, 32'hC3C30003};
        send(samples[0], st);
        in_data = samples[1];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== samples[0]) begin
                tests_failed++;
                $display("[TB] FAIL hold_cycle%0d got ready=%b valid=%b data=%h required 0 1 %h", i, in_ready, out_valid, out_data, samples[0]);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(samples[1], st);
        send(samples[2], st);
        in_valid = 1'b0;
        wait_idle(1'b1);
        model_words(0, 1'b0);
        tests_run++;
        if (obs_data.size() != exp_data.size()) begin
            tests_failed++;
            $display("[TB] FAIL hold_count got=%0d required=%0d", obs_data.size(), exp_data.size());
        end else begin
            foreach (exp_data[i]) begin
                tests_run++;
                if (obs_data[i] !== exp_data[i] || obs_partial[i] !== exp_partial[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL hold_word%0d got=%h/%b required=%h/%b", i, obs_data[i], obs_partial[i], exp_data[i], exp_partial[i]);
                end
            end
        end
    endtask

    task automatic test_disable();
        int st;
        set_mode(2'b01);
        out_ready = 1'b1;
        send(32'h77770055, st);
        in_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL disable_busy_before got=%b required=1", busy); end
        cfg_en = 1'b0;
        step(1);
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL disable_clear got busy=%b valid=%b required 0 0", busy, out_valid);
        end
        cfg_en = 1'b1;
        step(1);
        samples = '{32'h0000CAFE, 32'h1234BEEF};
        send(samples[0], st);
        send(samples[1], st);
        in_valid = 1'b0;
        wait_idle(1'b1);
        model_words(1, 1'b0);
        tests_run++;
        if (obs_data.size() != 1 || obs_data[0] !== exp_data[0] || obs_partial[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL disable_reenable got n=%0d data=%h required 1 %h", obs_data.size(),
                     (obs_data.size() > 0) ? obs_data[0] : 32'hx, exp_data[0]);
        end
    endtask

    task automatic test_reset_mid();
        int st;
        set_mode(2'b01);
        out_ready = 1'b1;
        send(32'h00009999, st);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid got busy=%b valid=%b required 0 0", busy, out_valid);
        end
        step(2);
        rst = 1'b0;
        step(4);
        tests_run++;
        if (obs_data.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_output got=%0d words required=0", obs_data.size());
        end
        cfg_mode = 2'b00;
        step(1);
    endtask

    task automatic test_random();
        int st;
        int mode;
        int count;
        bit do_flush;
        for (int r = 0; r < 10; r++) begin
            mode = $urandom_range(0, 3);
            set_mode(2'(mode));
            rand_ready = 1'b1;
            count = $urandom_range(1, 9);
            for (int i = 0; i < count; i++) begin
                samples.push_back($urandom);
                send(samples[i], st);
                if ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    step($urandom_range(1, 2));
                end
            end
            in_valid = 1'b0;
            do_flush = 1'($urandom_range(0, 1));
            if (do_flush) begin
                flush = 1'b1;
                step(1);
                flush = 1'b0;
            end
            wait_idle(do_flush);
            rand_ready = 1'b0;
            out_ready = 1'b1;
            step(2);
            model_words(mode, do_flush);
            tests_run++;
            if (obs_data.size() != exp_data.size()) begin
                tests_failed++;
                $display("[TB] FAIL random_r%0d_count got=%0d required=%0d", r, obs_data.size(), exp_data.size());
            end else begin
                foreach (exp_data[i]) begin
                    tests_run++;
                    if (obs_data[i] !== exp_data[i] || obs_partial[i] !== exp_partial[i]) begin
                        tests_failed++;
                        $display("[TB] FAIL random_r%0d_word%0d got=%h/%b required=%h/%b", r, i, obs_data[i], obs_partial[i], exp_data[i], exp_partial[i]);
                    end
                end
            end
        end
    endtask

`ifdef I2S_RX_PACKER_TIMEOUT_EN
    task automatic test_timeout();
        int st;
        int n;
        set_mode(2'b01);
        out_ready = 1'b1;
        cfg_timeout = 16'd10;
        samples = '{32'hFFFF1234};
        send(samples[0], st);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin
            step(1);
            n++;
        end
        model_words(1, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== exp_data[0] || out_partial !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_flush got valid=%b data=%h partial=%b required 1 %h 1", out_valid, out_data, out_partial, exp_data[0]);
        end
        tests_run++;
        if (n < 10) begin
            tests_failed++;
            $display("[TB] FAIL timeout_early got=%0d idle cycles required>=10", n);
        end
        wait_idle(1'b1);
        cfg_timeout = 16'd0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        cfg_en = 1'b0;
        cfg_mode = 2'b00;
        cfg_timeout = 16'd0;
        flush = 1'b0;
        in_data = 32'd0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_pack16();
        test_stream8();
        test_flush();
        test_back_to_back();
        test_disable();
        test_reset_mid();
        test_random();
`ifdef I2S_RX_PACKER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/i2s_rx_sample_packer.md
Name: i2s_rx_sample_packer

Overview:
- Sits between the I2S/PDM receive front end and the uDMA RX channel, in the I2S clock domain after the CDC FIFO.
- Consumes one 32-bit sample per valid/ready beat and packs 32/16/8-bit samples into 32-bit words, so narrow samples do not waste uDMA bandwidth and L2 space.
- Supports an explicit flush of a partially filled word at end of capture.

Parameters:
- TIMEOUT_W, 16, width of the idle-flush timeout counter (used only with the optional feature).

Ports:
- clk_i  in  1  block clock.
- rst_i  in  1  asynchronous active-high reset.
- cfg_en_i  in  1  packer enable; low clears the accumulator and blocks input.
- cfg_pack_mode_i  in  2  00 = 32-bit passthrough; 01 = 2x16-bit; 10 = 4x8-bit; 11 = treated as 00.
- cfg_timeout_i  in  TIMEOUT_W  idle cycles before auto-flush; 0 disables (used only with the optional feature).
- flush_i  in  1  single-cycle request to emit the partial word.
- in_data_i  in  32  sample, right-aligned.
- in_valid_i  in  1  sample valid.
- in_ready_o  out  1  sample accepted when valid and ready are both high.
- out_data_o  out  32  packed word.
- out_valid_o  out  1  packed word valid.
- out_ready_i  in  1  downstream ready.
- out_partial_o  out  1  current output word was produced by a flush (zero-padded).
- busy_o  out  1  accumulator non-empty, or flush pending.

Behaviour:
- Reset values: out_data_o = 0, out_valid_o = 0, out_partial_o = 0, busy_o = 0, in_ready_o = 0. Accumulator, slot count and flush-pending flag are all 0.
- Slots per word (N): 1 in mode 00/11, 2 in mode 01, 4 in mode 10.
- Slot k takes in_data_i[W-1:0] (W = 32/16/8) and places it at bits [k*W +: W]. First sample goes in the least-significant slot. Upper input bits are discarded.
- Storage: accumulator register (acc, cnt) plus one output register. State is FILL when cnt < N-1, LAST when cnt == N-1.
- Ready rule:
  - Non-last slot: in_ready_o = cfg_en_i & !flush_pend.
  - Last slot: in_ready_o = cfg_en_i & !flush_pend & (!out_valid_o | out_ready_i).
- Acceptance in a non-last slot: write the slot, cnt++.
- Acceptance in the last slot: next cycle out_data_o = acc | new sample, out_valid_o = 1, out_partial_o = 0; acc and cnt clear the same cycle. Latency is 1 cycle from the final beat to out_valid_o. Back-to-back full throughput is sustained while out_ready_i = 1.
- Output hold: out_valid_o stays high and out_data_o stays stable until out_ready_i.
- Flush:
  - flush_i with cnt == 0 and no pending flush: ignored, no output.
  - flush_i with cnt > 0: set flush_pend. When the output register is free or draining, load acc (zero-padded) with out_partial_o = 1, clear acc/cnt/flush_pend.
  - flush_i in the same cycle as an accepted beat: the beat is written first, then the flush applies to the result.
  - If that beat completes the word, a normal full word is emitted and no partial word follows.
- Disable: cfg_en_i low clears acc, cnt and flush_pend immediately; the partial word is lost. A word already in the output register is still delivered.
- Mode change: a change of cfg_pack_mode_i (registered copy compared each cycle) clears acc and cnt. Software changes mode only while disabled.
- busy_o = (cnt != 0) | flush_pend.
- Reset mid-operation: everything returns to reset values asynchronously, and no output word is produced.

Optional Feature:
- Macro I2S_RX_PACKER_TIMEOUT_EN.
- Defined:
  - An idle counter increments each cycle that cnt > 0 and no beat is accepted.
  - It resets on any acceptance or flush.
  - Reaching cfg_timeout_i (when nonzero) raises an internal flush, identical to flush_i.
- Undefined: counter logic is absent, cfg_timeout_i is ignored, and flushes come only from flush_i.

Decomposition:
- Shared package i2s_pkg:
  - pack_mode_e enum: PACK_32, PACK_16, PACK_8, PACK_RSVD.
  - Per-mode slot-count and slot-width constants.
- One natural sub-module: i2s_pack_out_stage, the output register with its valid/ready hold logic and partial flag.

Test Plan:
- Mode 01, inputs 0x1111AAAA then 0x2222BBBB, out_ready = 1 -> one word 0xBBBBAAAA, out_partial = 0, out_valid one cycle after the second beat.
- Mode 10, bytes 0x11, 0x22, 0x33, 0x44, 0x55, 0x66, 0x77, 0x88 streamed with valid held high -> 0x44332211 then 0x88776655, in_ready never low.
- Mode 10, three bytes 0xA1, 0xB2, 0xC3 then flush_i -> 0x00C3B2A1 with out_partial = 1; a second flush_i produces nothing.
- Mode 00, out_ready held low for 5 cycles after the first word -> out_data stable, in_ready low at the next beat, no loss; resume -> words delivered in order.
- Mode 01, one sample accepted, then cfg_en_i dropped -> busy_o = 0 next cycle, no output. Re-enable, send 2 samples -> a clean word with no stale data.
- With I2S_RX_PACKER_TIMEOUT_EN, cfg_timeout = 10, one 16-bit sample 0x1234 then idle -> partial word 0x00001234 after 10 idle cycles.
